// File: rtl/feat_buf_pkg.sv
// Shared feature-buffer definitions for the pooling, conv and FC engines.
package feat_buf_pkg;

  localparam int unsigned FEAT_DATA_W = 128;
  localparam int unsigned FEAT_LANES  = 16;
  localparam int unsigned FEAT_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } feat_state_e;

endpackage

// File: rtl/feat_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : synchronous read port, rd_data holds between reads
module feat_ram_sdp
  import feat_buf_pkg::*;
#(
  parameter int unsigned DATA_W = FEAT_DATA_W,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned IDX_W  = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/feat_buffer_bank.sv
// Feature-buffer responder: gated read/write access, range check, zero-fill
// sweep and fixed-latency read pipeline around feat_ram_sdp.
//   feat_rd_*  : read request in, data + valid strobe out after RD_LAT cycles
//   feat_wr_*  : write request
//   clr_start  : start zero-fill; busy while sweeping, clr_done pulse at end
//   addr_err   : sticky out-of-range flag, cleared by reset or accepted clr_start
module feat_buffer_bank
  import feat_buf_pkg::*;
#(
  parameter int unsigned DATA_W = FEAT_DATA_W,
  parameter int unsigned ADDR_W = FEAT_ADDR_W,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              feat_rd_en,
  input  logic [ADDR_W-1:0] feat_rd_local_addr,
  output logic [DATA_W-1:0] feat_rd_data,
  output logic              feat_rd_valid,
  input  logic              feat_wr_en,
  input  logic [ADDR_W-1:0] feat_wr_local_addr,
  input  logic [DATA_W-1:0] feat_wr_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              addr_err
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  feat_state_e       state;
  logic [IDX_W-1:0]  clr_cnt;

  logic              port_open;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_oor;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rd_data;

  logic              rd_v0;
  logic              rd_oor0;
  logic              rd_v1;
  logic [DATA_W-1:0] rd_d1;

  assign port_open   = (state != ST_CLEAR);
  assign rd_in_range = ({1'b0, feat_rd_local_addr} < DEPTH_L);
  assign wr_in_range = ({1'b0, feat_wr_local_addr} < DEPTH_L);
  assign rd_acc      = feat_rd_en && port_open;
  assign wr_acc      = feat_wr_en && port_open && wr_in_range;
  assign wr_oor      = feat_wr_en && port_open && !wr_in_range;

  always_comb begin
    ram_we    = wr_acc;
    ram_waddr = feat_wr_local_addr[IDX_W-1:0];
    ram_wdata = feat_wr_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end
  end

  feat_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (rd_acc && rd_in_range),
    .rd_addr (feat_rd_local_addr[IDX_W-1:0]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (state == ST_IDLE && clr_start) addr_err <= 1'b0;
      // a new error seen alongside clr_start is kept rather than lost
      if ((rd_acc && !rd_in_range) || wr_oor) addr_err <= 1'b1;
    end
  end

  // RAM output register is stage 0; out-of-range reads substitute zero at stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v0   <= 1'b0;
      rd_oor0 <= 1'b0;
      rd_v1   <= 1'b0;
      rd_d1   <= '0;
    end else begin
      rd_v0   <= rd_acc;
      rd_oor0 <= rd_acc && !rd_in_range;
      rd_v1   <= rd_v0;
      if (rd_v0) rd_d1 <= rd_oor0 ? '0 : ram_rd_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd_v2;
      logic [DATA_W-1:0] rd_d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_v2 <= 1'b0;
          rd_d2 <= '0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) rd_d2 <= rd_d1;
        end
      end
      assign feat_rd_valid = rd_v2;
      assign feat_rd_data  = rd_d2;
    end else begin : g_lat1
      assign feat_rd_valid = rd_v1;
      assign feat_rd_data  = rd_d1;
    end
  endgenerate

endmodule

// File: tb/tb_feat_buffer_bank.sv
module tb_feat_buffer_bank;

  logic         clk;
  logic         rst_n;

  logic         a_rd_en, a_wr_en, a_clr_start;
  logic [15:0]  a_rd_addr, a_wr_addr;
  logic [127:0] a_wr_data, a_rd_data;
  logic         a_rd_valid, a_busy, a_clr_done, a_addr_err;

  logic         b_rd_en, b_wr_en, b_clr_start;
  logic [15:0]  b_rd_addr, b_wr_addr;
  logic [127:0] b_wr_data, b_rd_data;
  logic         b_rd_valid, b_busy, b_clr_done, b_addr_err;

  int checks;
  int errors;

  feat_buffer_bank #(
    .DATA_W (128), .ADDR_W (16), .DEPTH (4096), .RD_LAT (1)
  ) dut_a (
    .clk (clk), .rst_n (rst_n),
    .feat_rd_en (a_rd_en), .feat_rd_local_addr (a_rd_addr),
    .feat_rd_data (a_rd_data), .feat_rd_valid (a_rd_valid),
    .feat_wr_en (a_wr_en), .feat_wr_local_addr (a_wr_addr),
    .feat_wr_data (a_wr_data), .clr_start (a_clr_start),
    .busy (a_busy), .clr_done (a_clr_done), .addr_err (a_addr_err)
  );

  feat_buffer_bank #(
    .DATA_W (128), .ADDR_W (16), .DEPTH (64), .RD_LAT (2)
  ) dut_b (
    .clk (clk), .rst_n (rst_n),
    .feat_rd_en (b_rd_en), .feat_rd_local_addr (b_rd_addr),
    .feat_rd_data (b_rd_data), .feat_rd_valid (b_rd_valid),
    .feat_wr_en (b_wr_en), .feat_wr_local_addr (b_wr_addr),
    .feat_wr_data (b_wr_data), .clr_start (b_clr_start),
    .busy (b_busy), .clr_done (b_clr_done), .addr_err (b_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int unsigned i);
    logic [127:0] v;
    for (int unsigned j = 0; j < 16; j++) v[j*8 +: 8] = 8'(i*16 + j + 1);
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    a_rd_en = 0; a_wr_en = 0; a_clr_start = 0; a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = 0; b_wr_en = 0; b_clr_start = 0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_rd_data !== '0 || a_rd_valid !== 1'b0 || a_busy !== 1'b0 || a_clr_done !== 1'b0 || a_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: data=%h valid=%b busy=%b done=%b err=%b, required all 0", a_rd_data, a_rd_valid, a_busy, a_clr_done, a_addr_err);
    end
    checks++;
    if (b_rd_data !== '0 || b_rd_valid !== 1'b0 || b_busy !== 1'b0 || b_clr_done !== 1'b0 || b_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: data=%h valid=%b busy=%b done=%b err=%b, required all 0", b_rd_data, b_rd_valid, b_busy, b_clr_done, b_addr_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read;
    logic [127:0] exp;
    exp = 128'h0F0E0D0C0B0A09080706050403020100;
    a_wr_en = 1; a_wr_addr = 16'd5; a_wr_data = exp;
    tick();
    a_wr_en = 0; a_rd_en = 1; a_rd_addr = 16'd5;
    tick();
    a_rd_en = 0;
    checks++;
    if (a_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_early_valid: got %b required 0", a_rd_valid);
    end
    tick();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== exp) begin
      errors++;
      $display("FAIL wr_rd_data: valid=%b data=%h required 1 %h", a_rd_valid, a_rd_data, exp);
    end
    tick();
    checks++;
    if (a_rd_valid !== 1'b0 || a_rd_data !== exp) begin
      errors++;
      $display("FAIL wr_rd_hold: valid=%b data=%h required 0 %h", a_rd_valid, a_rd_data, exp);
    end
  endtask

  task automatic test_read_first;
    a_wr_en = 1; a_wr_addr = 16'd9; a_wr_data = {16{8'h11}};
    tick();
    a_wr_data = {16{8'hAA}}; a_rd_en = 1; a_rd_addr = 16'd9;
    tick();
    a_wr_en = 0;
    tick();
    a_rd_en = 0;
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== {16{8'h11}}) begin
      errors++;
      $display("FAIL read_first_old: valid=%b data=%h required 1 %h", a_rd_valid, a_rd_data, {16{8'h11}});
    end
    tick();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== {16{8'hAA}}) begin
      errors++;
      $display("FAIL read_first_new: valid=%b data=%h required 1 %h", a_rd_valid, a_rd_data, {16{8'hAA}});
    end
  endtask

  task automatic test_out_of_range;
    int n;
    a_rd_en = 1; a_rd_addr = 16'd4096;
    tick();
    a_rd_en = 0;
    tick();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== '0 || a_addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: valid=%b data=%h err=%b required 1 0 1", a_rd_valid, a_rd_data, a_addr_err);
    end
    repeat (3) tick();
    checks++;
    if (a_addr_err !== 1'b1 || a_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL oor_sticky: err=%b valid=%b required 1 0", a_addr_err, a_rd_valid);
    end
    a_clr_start = 1;
    tick();
    a_clr_start = 0;
    checks++;
    if (a_addr_err !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL oor_clr: err=%b busy=%b required 0 1", a_addr_err, a_busy);
    end
    n = 0;
    while (a_busy && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4096 || a_clr_done !== 1'b1) begin
      errors++;
      $display("FAIL a_clear_len: busy_cycles=%0d done=%b required 4096 1", n, a_clr_done);
    end
    a_rd_en = 1; a_rd_addr = 16'd5;
    tick();
    a_rd_en = 0;
    tick();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== '0) begin
      errors++;
      $display("FAIL a_cleared_read: valid=%b data=%h required 1 0", a_rd_valid, a_rd_data);
    end
    a_wr_en = 1; a_wr_addr = 16'hFFFF; a_wr_data = {16{8'h55}};
    tick();
    a_wr_en = 0;
    checks++;
    if (a_addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_write: err=%b required 1", a_addr_err);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    bit exp_v;
    b_wr_en = 1;
    for (int i = 0; i < 49; i++) begin
      b_wr_addr = 16'(i); b_wr_data = pat(i);
      tick();
    end
    b_wr_en = 0;
    pulses = 0;
    for (int c = 0; c < 52; c++) begin
      b_rd_en = (c < 49); b_rd_addr = 16'(c);
      tick();
      exp_v = (c >= 2 && c <= 50);
      if (b_rd_valid === 1'b1) pulses++;
      checks++;
      if (b_rd_valid !== exp_v || (exp_v && b_rd_data !== pat(c - 2))) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%h required %b %h", c, b_rd_valid, b_rd_data, exp_v, pat(c - 2));
      end
    end
    b_rd_en = 0;
    checks++;
    if (pulses !== 49) begin
      errors++;
      $display("FAIL stream_count: got %0d required 49", pulses);
    end
  endtask

  task automatic test_clear;
    int n;
    b_clr_start = 1;
    tick();
    b_clr_start = 0;
    n = 0;
    while (b_busy && n < 200) begin
      b_wr_en = 1; b_wr_addr = 16'd10; b_wr_data = '1;
      b_rd_en = 1; b_rd_addr = 16'd10;
      tick();
      n++;
      checks++;
      if (b_rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL clear_rd_dropped[%0d]: valid=%b required 0", n, b_rd_valid);
      end
    end
    b_wr_en = 0; b_rd_en = 0;
    checks++;
    if (n !== 64 || b_clr_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_len: busy_cycles=%0d done=%b required 64 1", n, b_clr_done);
    end
    tick();
    checks++;
    if (b_clr_done !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_pulse: done=%b busy=%b required 0 0", b_clr_done, b_busy);
    end
    for (int c = 0; c < 66; c++) begin
      b_rd_en = (c < 64); b_rd_addr = 16'(c);
      tick();
      if (c >= 2) begin
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== '0) begin
          errors++;
          $display("FAIL cleared[%0d]: valid=%b data=%h required 1 0", c - 2, b_rd_valid, b_rd_data);
        end
      end
    end
    b_rd_en = 0;
  endtask

  task automatic test_reset_mid_clear;
    b_wr_en = 1; b_wr_addr = 16'd30; b_wr_data = pat(30);
    tick();
    b_wr_addr = 16'd10; b_wr_data = pat(10);
    tick();
    b_wr_en = 0;
    b_clr_start = 1;
    tick();
    b_clr_start = 0;
    repeat (20) tick();
    checks++;
    if (b_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy: got %b required 1", b_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_clr_done !== 1'b0 || b_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: busy=%b done=%b valid=%b required 0 0 0", b_busy, b_clr_done, b_rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    b_rd_en = 1; b_rd_addr = 16'd30;
    tick();
    b_rd_addr = 16'd10;
    tick();
    b_rd_en = 0;
    tick();
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== pat(30)) begin
      errors++;
      $display("FAIL partial_keep30: valid=%b data=%h required 1 %h", b_rd_valid, b_rd_data, pat(30));
    end
    tick();
    checks++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== '0) begin
      errors++;
      $display("FAIL partial_clear10: valid=%b data=%h required 1 0", b_rd_valid, b_rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_read_first();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/feat_buffer_bank.md
# feat_buffer_bank

Responder side of the feature-buffer port used by the layer engines (pooling, conv, FC). It stores 128-bit words (16 × int8 lanes) addressed by a 16-bit local word address. Each cycle it accepts one read and one write, and returns read data with a fixed latency and a `feat_rd_valid` strobe. It also provides a zero-fill sweep so an engine can start from a cleared bank.

## Interface
- `DATA_W`, 128: word width (16 lanes × 8 bit)
- `ADDR_W`, 16: local address width
- `DEPTH`, 4096: words stored; must satisfy DEPTH ≤ 2^ADDR_W
- `RD_LAT`, 1: read latency in cycles, legal values 1 or 2
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `feat_rd_en`  in  1  read request, sampled each cycle
- `feat_rd_local_addr`  in  ADDR_W  read word address
- `feat_rd_data`  out  DATA_W  read data, valid while `feat_rd_valid`=1
- `feat_rd_valid`  out  1  one pulse per accepted read
- `feat_wr_en`  in  1  write request
- `feat_wr_local_addr`  in  ADDR_W  write word address
- `feat_wr_data`  in  DATA_W  write data
- `clr_start`  in  1  request a zero-fill of all DEPTH words
- `busy`  out  1  zero-fill in progress
- `clr_done`  out  1  one-cycle pulse when the zero-fill completes
- `addr_err`  out  1  sticky flag: an out-of-range address was seen

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - `feat_rd_data`=0, `feat_rd_valid`=0, `busy`=0, `clr_done`=0, `addr_err`=0.
  - FSM in IDLE, clear counter at 0.
  - Memory contents are not reset.
- FSM states:
  - IDLE: service external reads and writes. `clr_start`=1 → CLEAR with counter=0.
  - CLEAR: write zero to address counter, then increment the counter. Leave for DONE after the write to DEPTH-1.
  - DONE: one cycle with `clr_done`=1, then IDLE.
- `busy`=1 exactly while in CLEAR.
- External reads:
  - Accepted when `feat_rd_en`=1 and state is IDLE or DONE.
  - Reads are dropped in CLEAR: no `feat_rd_valid`, and no data change.
- External writes:
  - Accepted when `feat_wr_en`=1 and state is IDLE or DONE.
  - Writes are dropped in CLEAR.
- `clr_start` outside IDLE is ignored.
- If reads or writes arrive in the same cycle as `clr_start` in IDLE, they are accepted; the clear begins on the next cycle.
- Same-address read and write in one cycle: the read returns the old contents (read-first). A read issued in the cycle after a write returns the new data.
- Out-of-range address (≥ DEPTH):
  - Write: dropped, and `addr_err` is set.
  - Read: accepted. `feat_rd_valid` pulses with `feat_rd_data`=0, and `addr_err` is set.
  - `addr_err` clears only on reset or on an accepted `clr_start`.
- Between read pulses, `feat_rd_data` holds its last value.
- Reset during CLEAR: the sweep aborts and memory is left partially cleared. This is legal; software re-issues `clr_start`.

## Timing
- Reads are fully pipelined: one read accepted per cycle, no bubbles.
- Read request accepted at edge N → `feat_rd_valid`=1 and data valid after edge N+RD_LAT, for exactly one cycle.
- RD_LAT=2 adds an output register stage. Both `feat_rd_valid` and `feat_rd_data` are delayed together.
- Write takes effect at the accepting edge.
- Zero-fill sequence:
  - `clr_start` sampled at edge S.
  - `busy` is 1 from edge S+1 through edge S+DEPTH.
  - `clr_done`=1 for the cycle after edge S+DEPTH.
  - Total clear time is DEPTH cycles.
- Reads accepted before or at edge S still return their `feat_rd_valid`, even if that lands while `busy`=1.

## Structure
- Package `feat_buf_pkg`:
  - Constants `FEAT_DATA_W`=128, `FEAT_LANES`=16, `FEAT_ADDR_W`=16.
  - FSM state encoding: IDLE, CLEAR, DONE.
  - Shared with the pooling, conv and FC engines.
- Sub-module `feat_ram_sdp`:
  - Inferred simple dual-port RAM: one write port, one synchronous read port, read-first behaviour.
  - `feat_buffer_bank` wraps it with the access gating, the address-range check, the clear mux on the write port and the latency pipeline.

## Test plan
- Write addr 5 = 0x0F0E…0100, then read addr 5 with RD_LAT=1 → `feat_rd_valid` one cycle after the read edge, data 0x0F0E…0100.
- In one cycle, write addr 9 = all 0xAA while reading addr 9 (old value all 0x11) → read returns all 0x11. The next read of addr 9 returns all 0xAA.
- Streaming reads of addrs 0..48 on consecutive cycles with RD_LAT=2 → 49 consecutive valid pulses, in order, each 2 cycles after its request.
- `clr_start` with DEPTH=64 → `busy` high for 64 cycles, then one `clr_done` pulse. Writes and reads during `busy` are ignored; afterwards every address reads 0.
- Read addr 4096 with DEPTH=4096 → valid pulse, data 0, `addr_err`=1 and held. A later `clr_start` clears `addr_err`.
- Assert `rst_n`=0 mid-clear (counter=20) → `busy`, `clr_done`, `feat_rd_valid` all 0 immediately. Address 30 keeps its previous nonzero content.
